// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side handshake/bus signals of mem_arbiter.
// slave modport is the arbiter's view; master is the environment's view
// (requesters plus memory).
interface mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  // requester 0 (cpu)
  logic              r0_rd_req;
  logic [ADDR_W-1:0] r0_rd_addr;
  logic [DATA_W-1:0] r0_rd_data;
  logic              r0_rd_ack;
  logic              r0_wr_req;
  logic [ADDR_W-1:0] r0_wr_addr;
  logic [DATA_W-1:0] r0_wr_data;
  logic              r0_wr_ready;
  // requester 1 (auxiliary master)
  logic              r1_rd_req;
  logic [ADDR_W-1:0] r1_rd_addr;
  logic [DATA_W-1:0] r1_rd_data;
  logic              r1_rd_ack;
  logic              r1_wr_req;
  logic [ADDR_W-1:0] r1_wr_addr;
  logic [DATA_W-1:0] r1_wr_data;
  logic              r1_wr_ready;
  // memory read/write ports
  logic              mem_read;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_read_ack;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              timeout_err;

  modport slave (
    input  r0_rd_req, r0_rd_addr, r0_wr_req, r0_wr_addr, r0_wr_data,
    input  r1_rd_req, r1_rd_addr, r1_wr_req, r1_wr_addr, r1_wr_data,
    input  mem_read_data, mem_read_ack,
    output r0_rd_data, r0_rd_ack, r0_wr_ready,
    output r1_rd_data, r1_rd_ack, r1_wr_ready,
    output mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data,
    output timeout_err
  );

  modport master (
    output r0_rd_req, r0_rd_addr, r0_wr_req, r0_wr_addr, r0_wr_data,
    output r1_rd_req, r1_rd_addr, r1_wr_req, r1_wr_addr, r1_wr_data,
    output mem_read_data, mem_read_ack,
    input  r0_rd_data, r0_rd_ack, r0_wr_ready,
    input  r1_rd_data, r1_rd_ack, r1_wr_ready,
    input  mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data,
    input  timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory read port and one write port between two
// requesters. Reads go through an IDLE/READ/DONE grant FSM with round-robin
// tie-break; each requester has a one-entry write buffer, and a requester's
// read is held off while its own write is still buffered.
// Optional: define MEM_ARB_TIMEOUT_EN to force READ completion (data all-ones,
// sticky timeout_err) after TIMEOUT_CYCLES cycles without mem_read_ack.

// One-entry write buffer for a single requester.
module mem_arb_wbuf #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              drain,
  output logic              accept,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  // a write arriving while full is dropped
  assign accept = wr_req & ~full;

  // capture on accept, empty after the cycle the entry was on mem_write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (accept) begin
      full <= 1'b1;
      addr <= wr_addr;
      data <= wr_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end
endmodule

module mem_arbiter #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DONE = 2'd2} state_t;

  state_t state_q, state_d;

  logic [NUM_REQ-1:0]             rd_req, wr_req, eligible;
  logic [NUM_REQ-1:0][ADDR_W-1:0] rd_addr, wr_addr, wb_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] wr_data, wb_data, rd_data_q;
  logic [NUM_REQ-1:0]             wb_accept, wb_full, full_n, drain_q, drain_d, rd_ack_q;

  // grant_q is both the latched grant and last_grant; resets to 1 so r0 wins the first tie
  logic              grant_q, grant_d;
  logic              start_rd, finish_rd, timed_out;
  logic              mem_read_q;
  logic [ADDR_W-1:0] mem_read_addr_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_write_addr_q, mw_addr_d;
  logic [DATA_W-1:0] mem_write_data_q, mw_data_d;

  assign rd_req  = {bus.r1_rd_req,  bus.r0_rd_req};
  assign rd_addr = {bus.r1_rd_addr, bus.r0_rd_addr};
  assign wr_req  = {bus.r1_wr_req,  bus.r0_wr_req};
  assign wr_addr = {bus.r1_wr_addr, bus.r0_wr_addr};
  assign wr_data = {bus.r1_wr_data, bus.r0_wr_data};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_wbuf
    mem_arb_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_req  (wr_req[g]),
      .wr_addr (wr_addr[g]),
      .wr_data (wr_data[g]),
      .drain   (drain_q[g]),
      .accept  (wb_accept[g]),
      .full    (wb_full[g]),
      .addr    (wb_addr[g]),
      .data    (wb_data[g])
    );
  end

  // a pending own write blocks the read so it observes that write
  assign eligible = rd_req & ~wb_full;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             timeout_err_q;

  // READ-cycle counter, cleared on entry to READ; sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (start_rd)              tmo_cnt_q <= '0;
      else if (state_q == READ)  tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (timed_out)             timeout_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // read FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // read FSM next state, grant choice and completion decode
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    start_rd  = 1'b0;
    finish_rd = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      IDLE: if (|eligible) begin
        start_rd = 1'b1;
        state_d  = READ;
        grant_d  = (&eligible) ? ~grant_q : eligible[1];
      end
      READ: if (bus.mem_read_ack) begin
        finish_rd = 1'b1;
        state_d   = DONE;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        finish_rd = 1'b1;
        timed_out = 1'b1;
        state_d   = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // read datapath: grant/address latch, mem_read strobe, ack pulse and data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q         <= 1'b1;
      mem_read_q      <= 1'b0;
      mem_read_addr_q <= '0;
      rd_ack_q        <= '0;
      rd_data_q       <= '0;
    end else begin
      rd_ack_q <= '0;
      if (start_rd) begin
        grant_q         <= grant_d;
        mem_read_q      <= 1'b1;
        mem_read_addr_q <= rd_addr[grant_d];
      end else if (finish_rd) begin
        mem_read_q          <= 1'b0;
        rd_ack_q[grant_q]   <= 1'b1;
        rd_data_q[grant_q]  <= timed_out ? {DATA_W{1'b1}} : bus.mem_read_data;
      end
    end
  end

  // pick next write to drain from post-edge buffer contents; lowest index wins
  always_comb begin
    full_n    = (wb_full & ~drain_q) | wb_accept;
    drain_d   = '0;
    mw_addr_d = '0;
    mw_data_d = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (full_n[i]) begin
        drain_d    = '0;
        drain_d[i] = 1'b1;
        mw_addr_d  = wb_accept[i] ? wr_addr[i] : wb_addr[i];
        mw_data_d  = wb_accept[i] ? wr_data[i] : wb_data[i];
      end
    end
  end

  // registered write strobe; drain_q tells the buffer it is on the bus this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_q          <= '0;
      mem_write_q      <= 1'b0;
      mem_write_addr_q <= '0;
      mem_write_data_q <= '0;
    end else begin
      drain_q          <= drain_d;
      mem_write_q      <= |drain_d;
      mem_write_addr_q <= mw_addr_d;
      mem_write_data_q <= mw_data_d;
    end
  end

  assign bus.r0_rd_data     = rd_data_q[0];
  assign bus.r1_rd_data     = rd_data_q[1];
  assign bus.r0_rd_ack      = rd_ack_q[0];
  assign bus.r1_rd_ack      = rd_ack_q[1];
  assign bus.r0_wr_ready    = ~wb_full[0];
  assign bus.r1_wr_ready    = ~wb_full[1];
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_read_addr  = mem_read_addr_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_write_addr = mem_write_addr_q;
  assign bus.mem_write_data = mem_write_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by a randomized phase against a
// transaction-level model (per-requester shadow memories and write queues).
module tb_mem_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int TMO    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  bit          auto_mem = 1'b0;
  logic        auto_ack = 1'b0, man_ack = 1'b0;
  logic [7:0]  auto_data = '0, man_data = '0;
  logic [7:0]  mem [0:4095];

  typedef struct { logic [11:0] a; logic [7:0] d; } wr_t;
  wr_t         wq0[$], wq1[$], went;
  logic [7:0]  shadow [0:1][0:15];
  bit          rd_pend [0:1];
  bit          acked [0:1];
  logic [3:0]  rd_idx [0:1];
  int          age [0:1];
  logic        ack_n, rdy_n;
  logic [7:0]  dat_n, wd;
  logic [3:0]  idx;
  int          r, cnt;
  bit          ok;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_read_ack  = auto_mem ? auto_ack  : man_ack;
  assign bus.mem_read_data = auto_mem ? auto_data : man_data;

  // memory model: applies writes, acks reads after a random 0..3 cycle wait
  initial begin
    int lat;
    lat = 0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_write) mem[bus.mem_write_addr] = bus.mem_write_data;
      auto_ack = 1'b0;
      if (auto_mem && bus.mem_read) begin
        if (lat == 0) begin
          auto_ack  = 1'b1;
          auto_data = mem[bus.mem_read_addr];
          lat       = $urandom_range(0, 3);
        end else lat--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.r0_rd_req = 0; bus.r0_rd_addr = '0; bus.r0_wr_req = 0; bus.r0_wr_addr = '0; bus.r0_wr_data = '0;
    bus.r1_rd_req = 0; bus.r1_rd_addr = '0; bus.r1_wr_req = 0; bus.r1_wr_addr = '0; bus.r1_wr_data = '0;
    man_ack = 0; man_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_mem_read(output bit got);
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus.mem_read) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic set_rd(input int n, input logic req, input logic [11:0] a);
    if (n == 0) begin bus.r0_rd_req = req; bus.r0_rd_addr = a; end
    else        begin bus.r1_rd_req = req; bus.r1_rd_addr = a; end
  endtask

  task automatic set_wr(input int n, input logic req, input logic [11:0] a, input logic [7:0] d);
    if (n == 0) begin bus.r0_wr_req = req; bus.r0_wr_addr = a; bus.r0_wr_data = d; end
    else        begin bus.r1_wr_req = req; bus.r1_wr_addr = a; bus.r1_wr_data = d; end
  endtask

  function automatic logic [11:0] addr_of(input int n, input logic [3:0] i);
    return {n[0], 7'd0, i};
  endfunction

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_read_addr", bus.mem_read_addr, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_r0_rd_ack", bus.r0_rd_ack, 0);
    chk("rst_r1_rd_ack", bus.r1_rd_ack, 0);
    chk("rst_r0_rd_data", bus.r0_rd_data, 0);
    chk("rst_r0_wr_ready", bus.r0_wr_ready, 1);
    chk("rst_r1_wr_ready", bus.r1_wr_ready, 1);
    chk("rst_timeout_err", bus.timeout_err, 0);
    rst_n = 1'b1;

    // single read, memory acks two cycles after mem_read rises
    set_rd(0, 1, 12'h200);
    tick();
    chk("sr_mem_read", bus.mem_read, 1);
    chk("sr_mem_read_addr", bus.mem_read_addr, 12'h200);
    chk("sr_no_early_ack", bus.r0_rd_ack, 0);
    tick();
    tick();
    chk("sr_mem_read_held", bus.mem_read, 1);
    man_ack = 1; man_data = 8'hA2;
    tick();
    man_ack = 0;
    chk("sr_rd_ack", bus.r0_rd_ack, 1);
    chk("sr_rd_data", bus.r0_rd_data, 8'hA2);
    chk("sr_mem_read_low_done", bus.mem_read, 0);
    chk("sr_r1_no_ack", bus.r1_rd_ack, 0);
    set_rd(0, 0, 12'h200);
    tick();
    chk("sr_ack_one_cycle", bus.r0_rd_ack, 0);
    chk("sr_data_hold", bus.r0_rd_data, 8'hA2);

    // contention from reset: r0, r1, r0, r1
    do_reset();
    set_rd(0, 1, 12'h100);
    set_rd(1, 1, 12'h180);
    for (int k = 0; k < 4; k++) begin
      wait_mem_read(ok);
      chk("ct_mem_read_seen", ok, 1);
      chk("ct_grant_addr", bus.mem_read_addr, (k % 2) ? 12'h180 : 12'h100);
      man_ack = 1; man_data = 8'h30 + 8'(k);
      tick();
      man_ack = 0;
      chk("ct_r0_ack", bus.r0_rd_ack, (k % 2) == 0);
      chk("ct_r1_ack", bus.r1_rd_ack, (k % 2) == 1);
      chk("ct_data", (k % 2) ? bus.r1_rd_data : bus.r0_rd_data, 8'h30 + 8'(k));
      chk("ct_no_overlap", bus.mem_read, 0);
      if (k == 3) begin set_rd(0, 0, '0); set_rd(1, 0, '0); end
      tick();
      chk("ct_ack_pulse", {bus.r1_rd_ack, bus.r0_rd_ack}, 2'b00);
    end

    // read-after-write on r1
    set_wr(1, 1, 12'h300, 8'h3F);
    tick();
    set_wr(1, 0, '0, '0);
    set_rd(1, 1, 12'h300);
    chk("raw_wr_ready_low", bus.r1_wr_ready, 0);
    chk("raw_mem_write", bus.mem_write, 1);
    chk("raw_mem_write_addr", bus.mem_write_addr, 12'h300);
    chk("raw_mem_write_data", bus.mem_write_data, 8'h3F);
    chk("raw_read_blocked", bus.mem_read, 0);
    tick();
    chk("raw_write_done", bus.mem_write, 0);
    chk("raw_wr_ready_back", bus.r1_wr_ready, 1);
    chk("raw_read_still_blocked", bus.mem_read, 0);
    tick();
    chk("raw_mem_read", bus.mem_read, 1);
    chk("raw_mem_read_addr", bus.mem_read_addr, 12'h300);
    man_ack = 1; man_data = 8'h3F;
    tick();
    man_ack = 0;
    chk("raw_rd_ack", bus.r1_rd_ack, 1);
    chk("raw_rd_data", bus.r1_rd_data, 8'h3F);
    set_rd(1, 0, '0);
    tick();

    // simultaneous writes: buffer 0 first, then buffer 1
    set_wr(0, 1, 12'h010, 8'h11);
    set_wr(1, 1, 12'h020, 8'h22);
    tick();
    set_wr(0, 0, '0, '0);
    set_wr(1, 0, '0, '0);
    chk("sw_t1_write", bus.mem_write, 1);
    chk("sw_t1_addr", bus.mem_write_addr, 12'h010);
    chk("sw_t1_data", bus.mem_write_data, 8'h11);
    chk("sw_t1_ready", {bus.r1_wr_ready, bus.r0_wr_ready}, 2'b00);
    tick();
    chk("sw_t2_write", bus.mem_write, 1);
    chk("sw_t2_addr", bus.mem_write_addr, 12'h020);
    chk("sw_t2_data", bus.mem_write_data, 8'h22);
    chk("sw_t2_ready", {bus.r1_wr_ready, bus.r0_wr_ready}, 2'b01);
    tick();
    chk("sw_t3_idle", bus.mem_write, 0);
    chk("sw_t3_ready", {bus.r1_wr_ready, bus.r0_wr_ready}, 2'b11);

    // write while not ready is dropped
    set_wr(0, 1, 12'h040, 8'h44);
    tick();
    chk("pv_ready_low", bus.r0_wr_ready, 0);
    set_wr(0, 1, 12'h050, 8'h55);
    chk("pv_first_addr", bus.mem_write_addr, 12'h040);
    chk("pv_first_data", bus.mem_write_data, 8'h44);
    tick();
    set_wr(0, 0, '0, '0);
    chk("pv_dropped", bus.mem_write, 0);
    chk("pv_ready_back", bus.r0_wr_ready, 1);
    tick();
    chk("pv_still_none", bus.mem_write, 0);

    // reset mid-READ, ack during and after reset is ignored, buffered write lost
    set_rd(0, 1, 12'h123);
    set_wr(0, 1, 12'h0C0, 8'hCC);
    tick();
    set_wr(0, 0, '0, '0);
    chk("rm_in_read", bus.mem_read, 1);
    rst_n = 1'b0;
    man_ack = 1; man_data = 8'h77;
    #1;
    chk("rm_mem_read_0", bus.mem_read, 0);
    chk("rm_mem_write_0", bus.mem_write, 0);
    chk("rm_acks_0", {bus.r1_rd_ack, bus.r0_rd_ack}, 2'b00);
    chk("rm_wr_ready", {bus.r1_wr_ready, bus.r0_wr_ready}, 2'b11);
    set_rd(0, 0, '0);
    tick();
    rst_n = 1'b1;
    tick();
    man_ack = 0;
    chk("rm_late_ack_ignored", bus.r0_rd_ack, 0);
    chk("rm_no_read", bus.mem_read, 0);
    chk("rm_write_lost", bus.mem_write, 0);
    set_rd(1, 1, 12'h321);
    tick();
    chk("rm_next_read", bus.mem_read, 1);
    chk("rm_next_addr", bus.mem_read_addr, 12'h321);
    man_ack = 1; man_data = 8'h5C;
    tick();
    man_ack = 0;
    chk("rm_next_ack", bus.r1_rd_ack, 1);
    chk("rm_next_data", bus.r1_rd_data, 8'h5C);
    set_rd(1, 0, '0);
    tick();

    // randomized traffic: r0 owns 0x00x, r1 owns 0x80x
    for (int a = 0; a < 4096; a++) mem[a] = 8'(a) ^ 8'h5A;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 16; i++) shadow[n][i] = 8'(i) ^ 8'h5A;
      rd_pend[n] = 0; age[n] = 0;
    end
    auto_mem = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        ack_n = n ? bus.r1_rd_ack : bus.r0_rd_ack;
        dat_n = n ? bus.r1_rd_data : bus.r0_rd_data;
        acked[n] = 1'b0;
        if (ack_n) begin
          chk("rnd_ack_owner", rd_pend[n], 1);
          chk("rnd_rd_data", dat_n, shadow[n][rd_idx[n]]);
          chk("rnd_rd_latency", age[n] <= 100, 1);
          rd_pend[n] = 1'b0;
          acked[n]   = 1'b1;
          set_rd(n, 0, '0);
        end else if (rd_pend[n]) age[n]++;
      end
      if (bus.mem_write) begin
        if (bus.mem_write_addr[11]) begin
          chk("rnd_wr1_pending", wq1.size() > 0, 1);
          if (wq1.size() > 0) begin
            went = wq1.pop_front();
            chk("rnd_wr1_addr", bus.mem_write_addr, went.a);
            chk("rnd_wr1_data", bus.mem_write_data, went.d);
          end
        end else begin
          chk("rnd_wr0_pending", wq0.size() > 0, 1);
          if (wq0.size() > 0) begin
            went = wq0.pop_front();
            chk("rnd_wr0_addr", bus.mem_write_addr, went.a);
            chk("rnd_wr0_data", bus.mem_write_data, went.d);
          end
        end
      end
      set_wr(0, 0, '0, '0);
      set_wr(1, 0, '0, '0);
      if (cyc < 600) begin
        for (int n = 0; n < 2; n++) begin
          if (!rd_pend[n] && !acked[n]) begin
            r     = $urandom_range(0, 9);
            idx   = 4'($urandom_range(0, 15));
            rdy_n = n ? bus.r1_wr_ready : bus.r0_wr_ready;
            if (r < 3) begin
              rd_pend[n] = 1'b1;
              rd_idx[n]  = idx;
              age[n]     = 0;
              set_rd(n, 1, addr_of(n, idx));
            end else if (r < 6 && rdy_n) begin
              wd = 8'($urandom);
              shadow[n][idx] = wd;
              if (n == 0) wq0.push_back('{a: addr_of(0, idx), d: wd});
              else        wq1.push_back('{a: addr_of(1, idx), d: wd});
              set_wr(n, 1, addr_of(n, idx), wd);
            end
          end
        end
      end
      tick();
    end
    chk("rnd_r0_drained", rd_pend[0], 0);
    chk("rnd_r1_drained", rd_pend[1], 0);
    chk("rnd_wq0_empty", wq0.size(), 0);
    chk("rnd_wq1_empty", wq1.size(), 0);
    auto_mem = 1'b0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // memory never acks: forced completion after TMO READ cycles
    set_rd(0, 1, 12'h0AB);
    wait_mem_read(ok);
    chk("to_mem_read_seen", ok, 1);
    cnt = 0;
    while (bus.mem_read && cnt < 64) begin
      cnt++;
      tick();
    end
    chk("to_read_cycles", cnt, TMO);
    chk("to_rd_ack", bus.r0_rd_ack, 1);
    chk("to_rd_data", bus.r0_rd_data, 8'hFF);
    chk("to_err", bus.timeout_err, 1);
    set_rd(0, 0, '0);
    tick();
    tick();
    chk("to_err_sticky", bus.timeout_err, 1);
    chk("to_ack_gone", bus.r0_rd_ack, 0);
`else
    // without the timeout option READ waits for the ack indefinitely
    set_rd(0, 1, 12'h0AB);
    wait_mem_read(ok);
    chk("nt_mem_read_seen", ok, 1);
    repeat (40) tick();
    chk("nt_still_read", bus.mem_read, 1);
    chk("nt_no_ack", bus.r0_rd_ack, 0);
    chk("nt_err_tied", bus.timeout_err, 0);
    man_ack = 1; man_data = 8'h9E;
    tick();
    man_ack = 0;
    chk("nt_rd_ack", bus.r0_rd_ack, 1);
    chk("nt_rd_data", bus.r0_rd_data, 8'h9E);
    set_rd(0, 0, '0);
    tick();
    chk("nt_err_after", bus.timeout_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single memory read port and write port between two requesters: requester 0 (cpu) and requester 1 (auxiliary master, e.g. display fetch or ROM loader). The block sits between the requesters and memory. It sequences reads with a grant state machine and round-robin fairness, buffers one write per requester, and keeps read-after-write order within each requester.

Parameters:
ADDR_W, 12, address width (4 KiB space)
DATA_W, 8, data width
TIMEOUT_CYCLES, 16, READ-state cycles before forced completion (only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rN_rd_req  in  1  (N=0,1) read request level; held with stable address until rN_rd_ack
rN_rd_addr  in  ADDR_W  read address
rN_rd_data  out  DATA_W  registered read data, valid while rN_rd_ack=1
rN_rd_ack  out  1  one-cycle completion pulse
rN_wr_req  in  1  one-cycle write pulse; accepted only when rN_wr_ready=1
rN_wr_addr  in  ADDR_W  write address
rN_wr_data  in  DATA_W  write data
rN_wr_ready  out  1  write buffer empty
mem_read  out  1  memory read strobe, held until mem_read_ack
mem_read_addr  out  ADDR_W  registered read address
mem_read_data  in  DATA_W  memory read data, valid with mem_read_ack
mem_read_ack  in  1  memory read completion pulse
mem_write  out  1  one-cycle memory write strobe
mem_write_addr  out  ADDR_W  write address
mem_write_data  out  DATA_W  write data
timeout_err  out  1  sticky timeout flag (tied 0 without MEM_ARB_TIMEOUT_EN)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; rN_wr_ready=1.
  - Write buffers empty; last_grant=1, so r0 wins the first tie.
- Read FSM, states IDLE -> READ -> DONE -> IDLE:
  - IDLE: sample rd_req. Requester N is eligible if rN_rd_req=1 and its write buffer is empty.
  - If both are eligible, grant the one not equal to last_grant. Latch grant and address; update last_grant; go to READ.
  - READ: mem_read=1 and mem_read_addr=latched address, both registered.
  - On mem_read_ack in READ: latch mem_read_data; go to DONE; mem_read=0 in the DONE cycle.
  - DONE: rN_rd_ack=1 for the granted N for exactly one cycle, with rN_rd_data valid. Requests are not sampled in DONE. Go to IDLE.
  - A request still high in IDLE after DONE is a new request.
- Read latency:
  - Request seen in IDLE at cycle 0 -> mem_read high from cycle 1.
  - Memory ack at cycle k -> rd_ack at cycle k+1.
  - Minimum read is 3 cycles (ack at k=1 gives rd_ack at cycle 2).
- rd_data holds its last value between acks.
- Ack handling: mem_read_ack outside READ is ignored. A requester dropping rd_req mid-READ is illegal; the transaction completes and the ack still pulses.
- Writes:
  - rN_wr_req with rN_wr_ready=1 loads buffer N; wr_ready drops next cycle.
  - Drain one write per cycle: mem_write=1 with the buffered address and data, registered, at the earliest 1 cycle after capture.
  - If both buffers are full, buffer 0 drains first, buffer 1 the next cycle.
  - The buffer empties and wr_ready rises the cycle after its mem_write.
  - A write accepted while wr_ready=0 is a protocol violation; the request is dropped and the buffer is unchanged.
- Ordering:
  - A requester's read is not granted while its own write buffer is full, so its read observes its own prior write.
  - No ordering is enforced across requesters.
  - Reads and writes to memory may overlap (separate ports).
- Reset mid-READ: the FSM returns to IDLE immediately; a late mem_read_ack is ignored; buffered writes are lost.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- When defined: a cycle counter runs in READ. If mem_read_ack has not arrived after TIMEOUT_CYCLES cycles in READ, the FSM goes to DONE with rd_data={DATA_W{1'b1}} and sets timeout_err=1. timeout_err is sticky until reset. The counter clears on entry to READ.
- When undefined: no counter; READ waits indefinitely; timeout_err is tied 0.

Test Plan:
- Single read: r0 requests addr 0x200; memory acks 2 cycles after mem_read with 0xA2 -> mem_read_addr=0x200; r0_rd_ack one cycle later with data 0xA2; mem_read low in the DONE cycle.
- Contention: r0 and r1 both request from reset, held -> grant order r0, r1, r0, r1; each ack one cycle only; no overlapping mem_read transactions.
- Read-after-write: r1 writes 0x3F to 0x300, then reads 0x300 next cycle -> mem_write (0x300, 0x3F) precedes mem_read for r1; r1_wr_ready returns to 1.
- Simultaneous writes: both pulse wr_req in the same cycle (r0: 0x010/0x11, r1: 0x020/0x22) -> mem_write 0x010 at t+1 and 0x020 at t+2; both wr_ready high at t+3.
- Reset mid-READ: assert rst_n=0 while in READ, deliver mem_read_ack during reset and after release -> no rd_ack; all outputs 0; next request serviced normally.
- Timeout (macro on, TIMEOUT_CYCLES=16): memory never acks -> rd_ack after 16 READ cycles with data 0xFF; timeout_err=1 and stays 1.
